// File: rtl/bcd_calc_pkg.sv
// Shared types, glyph constants and helpers for the sequential BCD calculator.
package bcd_calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_DIGIT = 2'd1,
      ERR_DIV0  = 2'd2,
      ERR_OVF   = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_CONV,
      S_EXEC,
      S_B2BCD,
      S_DONE
   } state_e;

   // Segment order {g,f,e,d,c,b,a}, active low
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;

   function automatic logic [6:0] seg7_dec(input logic [3:0] d);
      case (d)
         4'h0:    seg7_dec = 7'b1000000;
         4'h1:    seg7_dec = 7'b1111001;
         4'h2:    seg7_dec = 7'b0100100;
         4'h3:    seg7_dec = 7'b0110000;
         4'h4:    seg7_dec = 7'b0011001;
         4'h5:    seg7_dec = 7'b0010010;
         4'h6:    seg7_dec = 7'b0000010;
         4'h7:    seg7_dec = 7'b1111000;
         4'h8:    seg7_dec = 7'b0000000;
         4'h9:    seg7_dec = 7'b0010000;
         4'hA:    seg7_dec = 7'b0001000;
         4'hB:    seg7_dec = 7'b0000011;
         4'hC:    seg7_dec = 7'b1000110;
         4'hD:    seg7_dec = 7'b0100001;
         4'hE:    seg7_dec = 7'b0000110;
         default: seg7_dec = 7'b0001110;
      endcase
   endfunction

   function automatic logic [63:0] pow10(input int n);
      pow10 = 64'd1;
      for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
   endfunction

endpackage

// File: rtl/bcd_seq_calc_if.sv
// Request/result bundle between switch-capture logic and the BCD calculator.
interface bcd_seq_calc_if #(
   parameter int N_DIG   = 2,
   parameter int RES_DIG = 4
);
   logic                   start;
   logic [4*N_DIG-1:0]     op_a;
   logic [4*N_DIG-1:0]     op_b;
   logic [1:0]             opcode;
   logic                   busy;
   logic                   done;
   logic [1:0]             err;
   logic                   neg;
   logic [4*RES_DIG-1:0]   result_bcd;
   logic [7*RES_DIG-1:0]   hex_out;

   modport master (
      output start, op_a, op_b, opcode,
      input  busy, done, err, neg, result_bcd, hex_out
   );

   modport slave (
      input  start, op_a, op_b, opcode,
      output busy, done, err, neg, result_bcd, hex_out
   );
endinterface

// File: rtl/bcd_seq_b2bcd.sv
// Serial double-dabble converter: W-bit binary to DIG BCD digits in W cycles.
module bcd_seq_b2bcd #(
   parameter int W   = 14,
   parameter int DIG = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [W-1:0]     i_bin,
   output logic             o_done,
   output logic [4*DIG-1:0] o_bcd
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]     r_bin;
   logic [4*DIG-1:0] r_bcd;
   logic [4*DIG-1:0] w_adj;
   logic [CW-1:0]    r_cnt;
   logic             r_run;
   logic             w_last;

   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < DIG; k++)
         if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
   end

   assign w_last = r_run && (r_cnt == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_start) begin
         r_bin <= i_bin;
         r_bcd <= '0;
         r_cnt <= '0;
         r_run <= 1'b1;
      end else if (r_run) begin
         r_bcd <= (w_adj << 1) | {{(4*DIG-1){1'b0}}, r_bin[W-1]};
         r_bin <= r_bin << 1;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) r_run <= 1'b0;
      end
   end

   assign o_done = w_last;
   assign o_bcd  = r_bcd;
endmodule

// File: rtl/bcd_seq_calc.sv
// Sequential BCD add/sub/mul/div unit driving active-low 7-segment digits.
// Build option BCD_SEQ_CALC_LZB_EN blanks leading zeros of non-error results.
module bcd_seq_calc
   import bcd_calc_pkg::*;
#(
   parameter int N_DIG   = 2,
   parameter int RES_DIG = 4
) (
   input  logic          CLOCK_50,
   input  logic          RST_N,
   bcd_seq_calc_if.slave bus
);
   localparam int          OPW     = $clog2(10**N_DIG);
   localparam int          RW      = 2 * OPW;
   localparam int          CW      = $clog2(OPW + 1);
   localparam logic [63:0] LIM_POS = pow10(RES_DIG);
   localparam logic [63:0] LIM_NEG = pow10(RES_DIG - 1);

   state_e               r_state, w_next_state;
   op_e                  r_op;
   err_e                 r_err_int, r_err;
   logic [4*N_DIG-1:0]   r_a_bcd, r_b_bcd;
   logic [CW-1:0]        r_cnt;
   logic [RW-1:0]        r_acc_a, r_res, w_res_nxt;
   logic [OPW-1:0]       r_acc_b, r_rem, w_rem_nxt;
   logic [OPW:0]         w_rem_sh;
   logic                 r_neg_int, w_neg_nxt;
   logic                 w_bad_digit, w_div0, w_conv_last, w_exec_last, w_ovf;
   logic                 w_accept, w_b2_start, w_b2_done;
   logic [4*RES_DIG-1:0] w_bcd, r_result;
   logic [7*RES_DIG-1:0] w_hex, r_hex;
   logic                 r_busy, r_done, r_neg;
`ifdef BCD_SEQ_CALC_LZB_EN
   int                   w_msd;
`endif

   // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (bus.start) w_next_state = S_CHECK;
         S_CHECK: w_next_state = (w_bad_digit || w_div0) ? S_DONE : S_CONV;
         S_CONV:  if (w_conv_last) w_next_state = S_EXEC;
         S_EXEC:  if (w_exec_last) w_next_state = w_ovf ? S_DONE : S_B2BCD;
         S_B2BCD: if (w_b2_done) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept   = (r_state == S_IDLE) && bus.start;
      w_b2_start = (r_state == S_EXEC) && w_exec_last && !w_ovf;
   end

   always_comb begin
      w_bad_digit = 1'b0;
      for (int k = 0; k < N_DIG; k++)
         if (r_a_bcd[4*k +: 4] > 4'd9 || r_b_bcd[4*k +: 4] > 4'd9) w_bad_digit = 1'b1;
   end

   assign w_div0      = (r_op == OP_DIV) && (r_b_bcd == '0);
   assign w_conv_last = (r_cnt == CW'(N_DIG - 1));
   assign w_exec_last = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_cnt == CW'(OPW - 1));
   assign w_ovf       = w_neg_nxt ? (64'(w_res_nxt) >= LIM_NEG) : (64'(w_res_nxt) >= LIM_POS);

   // One EXEC step; mul and div walk through OPW of these.
   always_comb begin
      w_res_nxt = r_res;
      w_neg_nxt = 1'b0;
      w_rem_sh  = {r_rem, r_acc_a[OPW-1]};
      w_rem_nxt = r_rem;
      unique case (r_op)
         OP_ADD: w_res_nxt = r_acc_a + RW'(r_acc_b);
         OP_SUB: begin
            if (r_acc_a >= RW'(r_acc_b)) begin
               w_res_nxt = r_acc_a - RW'(r_acc_b);
            end else begin
               w_res_nxt = RW'(r_acc_b) - r_acc_a;
               w_neg_nxt = 1'b1;
            end
         end
         OP_MUL: if (r_acc_b[0]) w_res_nxt = r_res + r_acc_a;
         OP_DIV: begin
            if (w_rem_sh >= {1'b0, r_acc_b}) begin
               w_rem_nxt = OPW'(w_rem_sh - {1'b0, r_acc_b});
               w_res_nxt = (r_res << 1) | RW'(1);
            end else begin
               w_rem_nxt = w_rem_sh[OPW-1:0];
               w_res_nxt = r_res << 1;
            end
         end
      endcase
   end

   // NOTE: datapath registers are reset too, so an abandoned operation leaves no residue.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         r_op      <= OP_ADD;
         r_a_bcd   <= '0;
         r_b_bcd   <= '0;
         r_cnt     <= '0;
         r_acc_a   <= '0;
         r_acc_b   <= '0;
         r_rem     <= '0;
         r_res     <= '0;
         r_neg_int <= 1'b0;
         r_err_int <= ERR_NONE;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_accept) begin
               r_a_bcd <= bus.op_a;
               r_b_bcd <= bus.op_b;
               r_op    <= op_e'(bus.opcode);
            end
            S_CHECK: begin
               r_cnt     <= '0;
               r_acc_a   <= '0;
               r_acc_b   <= '0;
               r_rem     <= '0;
               r_res     <= '0;
               r_neg_int <= 1'b0;
               r_err_int <= w_bad_digit ? ERR_DIGIT : (w_div0 ? ERR_DIV0 : ERR_NONE);
            end
            S_CONV: begin
               r_acc_a <= r_acc_a * RW'(10) + RW'(r_a_bcd[4*N_DIG-1 -: 4]);
               r_acc_b <= r_acc_b * OPW'(10) + OPW'(r_b_bcd[4*N_DIG-1 -: 4]);
               r_a_bcd <= r_a_bcd << 4;
               r_b_bcd <= r_b_bcd << 4;
               r_cnt   <= w_conv_last ? '0 : r_cnt + 1'b1;
            end
            S_EXEC: begin
               r_res     <= w_res_nxt;
               r_neg_int <= w_neg_nxt;
               r_rem     <= w_rem_nxt;
               r_acc_a   <= r_acc_a << 1;
               if (r_op == OP_MUL) r_acc_b <= r_acc_b >> 1;
               r_cnt     <= r_cnt + 1'b1;
               if (w_exec_last && w_ovf) r_err_int <= ERR_OVF;
            end
            default: ;
         endcase
      end
   end

   bcd_seq_b2bcd #(.W(RW), .DIG(RES_DIG)) u_b2bcd (
      .clk     (CLOCK_50),
      .rst_n   (RST_N),
      .i_start (w_b2_start),
      .i_bin   (w_res_nxt),
      .o_done  (w_b2_done),
      .o_bcd   (w_bcd)
   );

   always_comb begin
      w_hex = '1;
`ifdef BCD_SEQ_CALC_LZB_EN
      w_msd = 0;
`endif
      if (r_err_int != ERR_NONE) begin
         w_hex[6:0]   = SEG_R;
         w_hex[13:7]  = SEG_R;
         w_hex[20:14] = SEG_E;
         w_hex[27:21] = seg7_dec({2'b00, r_err_int});
      end else begin
         for (int k = 0; k < RES_DIG; k++) w_hex[7*k +: 7] = seg7_dec(w_bcd[4*k +: 4]);
`ifdef BCD_SEQ_CALC_LZB_EN
         for (int k = 1; k < RES_DIG; k++)
            if (w_bcd[4*k +: 4] != 4'd0) w_msd = k;
         for (int k = 1; k < RES_DIG; k++) begin
            if (k > w_msd) w_hex[7*k +: 7] = SEG_BLANK;
            if (r_neg_int && k == w_msd + 1) w_hex[7*k +: 7] = SEG_MINUS;
         end
`else
         if (r_neg_int) w_hex[7*(RES_DIG-1) +: 7] = SEG_MINUS;
`endif
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= ERR_NONE;
         r_neg    <= 1'b0;
         r_result <= '0;
         r_hex    <= '1;
      end else begin
         r_done <= 1'b0;
         if (w_accept) r_busy <= 1'b1;
         if (r_state == S_DONE) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= r_err_int;
            r_neg    <= (r_err_int == ERR_NONE) && r_neg_int;
            r_result <= (r_err_int == ERR_NONE) ? w_bcd : '0;
            r_hex    <= w_hex;
         end
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.neg        = r_neg;
   assign bus.result_bcd = r_result;
   assign bus.hex_out    = r_hex;
endmodule

// File: doc/bcd_seq_calc.md
Name: bcd_seq_calc

Overview:
- Clocked, parametrised BCD arithmetic unit for the DE2 switch/7-segment calculator.
- Takes two N_DIG-digit BCD operands and a 2-bit opcode on a start pulse. Computes add, sub, mul or div serially in binary, then converts the result back to BCD.
- Drives RES_DIG active-low 7-segment digits, including a minus sign and error codes.
- Sits between the switch-capture logic and the HEX pins; replaces the combinational two-digit calculator.

Parameters:
- N_DIG, 2, digits per operand (1..4).
- RES_DIG, 4, result display digits (>= 4, >= N_DIG+1).

Ports:
- CLOCK_50  in   1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op_a  in  4*N_DIG  BCD operand A, most significant digit in the top nibble.
- op_b  in  4*N_DIG  BCD operand B.
- opcode  in  2  0 add, 1 sub, 2 mul, 3 div (integer quotient).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result registers update.
- err  out  2  0 none, 1 invalid digit, 2 divide by zero, 3 overflow.
- neg  out  1  result negative (sub only).
- result_bcd  out  4*RES_DIG  magnitude in BCD.
- hex_out  out  7*RES_DIG  segments; digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}, active low.

Behaviour:
- Derived widths:
  - OPW = $clog2(10**N_DIG); RW = 2*OPW. Defaults: OPW=7, RW=14.
- Reset (async, RST_N=0):
  - FSM to IDLE; busy=0, done=0, err=0, neg=0, result_bcd=0.
  - hex_out all ones (blank).
  - Internal datapath cleared; an operation in flight is abandoned, with no done pulse.
- FSM states: IDLE -> CHECK -> CONV -> EXEC -> B2BCD -> DONE -> IDLE.
- IDLE: on start=1, latch op_a, op_b and opcode; go to CHECK. Operands are not re-sampled afterwards.
- CHECK (1 cycle):
  - Any nibble > 9 -> err=1, go to DONE.
  - Else if opcode=3 and op_b is all zero -> err=2, go to DONE.
  - Else go to CONV.
- CONV (N_DIG cycles): per cycle, acc_x = acc_x*10 + next digit, for both operands in parallel, most significant digit first.
- EXEC:
  - Add: 1 cycle.
  - Sub: 1 cycle. If A<B, magnitude = B-A and neg=1; zero result gives neg=0.
  - Mul: OPW cycles, shift-add, LSB of B first.
  - Div: OPW cycles, restoring, quotient only.
- Overflow check at end of EXEC:
  - neg=0 and result >= 10**RES_DIG -> err=3.
  - neg=1 and magnitude >= 10**(RES_DIG-1) -> err=3.
  - On overflow, go to DONE.
- B2BCD (RW cycles): double-dabble shift (add 3 to any nibble >= 5, then shift left).
- DONE (1 cycle): register result_bcd, neg, err and hex_out; pulse done; busy falls in the same cycle.
- Latency, start to done (defaults): add/sub 19 cycles, mul/div 25, invalid/div0 3.
- hex_out when err=0:
  - Each result digit is decoded 0-9.
  - If neg=1, a "-" is placed in the leftmost digit.
- hex_out when err!=0:
  - Digits 2..0 show "E","r","r" (0000110, 0101111, 0101111).
  - Digit 3 shows the err value as a decimal digit.
  - Higher digits are blank.
  - result_bcd=0, neg=0.
- Outputs hold their last value until the next DONE or reset.
- start while busy is ignored; no queueing.
- start on the same cycle as DONE is ignored; it is accepted from the next IDLE cycle.

Optional Feature:
- Macro: BCD_SEQ_CALC_LZB_EN.
- Defined: leading-zero digits of a non-error result are blanked, except digit 0. With neg=1, the "-" sits immediately left of the most significant non-zero digit.
- Undefined: all RES_DIG digits are shown with leading zeros, and "-" is in the leftmost digit.
- result_bcd is identical in both builds.

Decomposition:
- Package bcd_calc_pkg holds:
  - opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - err enum;
  - FSM state enum;
  - glyph constants (SEG_BLANK, SEG_MINUS, SEG_E, SEG_R);
  - function seg7_dec(4-bit) returning the active-low pattern for 0-F.
- One sub-module, bcd_seq_b2bcd: parametrised RW-to-BCD double-dabble engine with start/done.

Test Plan:
- A=12, B=34, add -> after 19 cycles done=1; result_bcd=0x0046; neg=0; hex_out digits "0046".
- A=05, B=42, sub -> result_bcd=0x0037; neg=1; digit 3 shows "-".
- A=99, B=99, mul -> after 25 cycles result_bcd=0x9801; err=0. Repeat with N_DIG=3: A=999, B=999 -> err=3, "3Err".
- A=57, B=00, div -> done after 3 cycles; err=2; "2Err". A=1A (nibble 0xA) -> err=1.
- Assert RST_N low mid-MUL -> all outputs return to reset values; no done pulse. A new start after release completes normally.
- BCD_SEQ_CALC_LZB_EN build: A=03, B=04, add -> digits blank, blank, blank, "7".
